// File: rtl/cache_pkg.sv
// Shared state encoding, default-geometry constants and address-field helpers
// for the set-associative read cache.
package cache_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} cache_state_e;

   localparam int ADDR_W_DEF     = 19;
   localparam int INDEX_W_DEF    = 6;
   localparam int LINE_WORDS_DEF = 2;
   localparam int OFF_W          = $clog2(LINE_WORDS_DEF);
   localparam int TAG_W          = ADDR_W_DEF - INDEX_W_DEF - OFF_W - 2;
   localparam int LINE_W         = 32 * LINE_WORDS_DEF;

   function automatic logic [31:0] field_mask(input int bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

   // Index sits in the topmost address bits, tag just below it, then the word offset.
   function automatic logic [31:0] addr_index(input logic [31:0] a, input int addr_w,
                                              input int index_w);
      return (a >> (addr_w - index_w)) & field_mask(index_w);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] a, input int addr_w,
                                            input int index_w, input int off_w);
      return (a >> (off_w + 2)) & field_mask(addr_w - index_w - off_w - 2);
   endfunction

   function automatic logic [31:0] addr_word(input logic [31:0] a, input int off_w);
      return (a >> 2) & field_mask(off_w);
   endfunction
endpackage

// File: rtl/assoc_cache_ctrl_plru_tree.sv
// Tree pseudo-LRU for one set: victim choice (invalid ways first) and the
// updated tree after an access. Node n has children 2n+1 (left) and 2n+2 (right).
module plru_tree #(
   parameter int WAYS = 2
) (
   input  logic [WAYS-2:0]         tree,
   input  logic [WAYS-1:0]         valid,
   input  logic [$clog2(WAYS)-1:0] access_way,
   output logic [$clog2(WAYS)-1:0] victim,
   output logic [WAYS-2:0]         next_tree
);
   localparam int LEVELS = $clog2(WAYS);

   always_comb begin
      logic [LEVELS-1:0] node;
      victim = '0;
      node   = '0;
      for (int l = 0; l < LEVELS; l++) begin
         victim[LEVELS-1-l] = tree[node];
         node = LEVELS'(32'(node) * 2 + 1 + 32'(tree[node]));
      end
      // Descending scan so the lowest-numbered invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) victim = LEVELS'(w);
      end
   end

   always_comb begin
      logic [LEVELS-1:0] node;
      logic              dir;
      next_tree = tree;
      node      = '0;
      for (int l = 0; l < LEVELS; l++) begin
         dir             = access_way[LEVELS-1-l];
         next_tree[node] = ~dir;
         node = LEVELS'(32'(node) * 2 + 1 + 32'(dir));
      end
   end
endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-through read cache between the MEM stage and the
// SRAM controller, with line fill, write-hit update and whole-cache flush.
module assoc_cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 19,
   parameter int INDEX_W    = 6,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rd_en,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [31:0]              wdata,
   input  logic                     flush,
   output logic [31:0]              rdata,
   output logic                     ready,
   output logic                     mem_rd_en,
   output logic                     mem_wr_en,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic [32*LINE_WORDS-1:0] mem_rdata,
   input  logic                     mem_ready
);
   localparam int SETS      = 1 << INDEX_W;
   localparam int OFF_BITS  = $clog2(LINE_WORDS);
   localparam int TAG_BITS  = ADDR_W - INDEX_W - OFF_BITS - 2;
   localparam int WAY_BITS  = $clog2(WAYS);
   localparam int WORD_BITS = (OFF_BITS > 0) ? OFF_BITS : 1;

   cache_state_e state;
   logic         flush_pend;

   logic [WAYS-1:0]     valid_q [SETS];
   logic [WAYS-2:0]     plru_q  [SETS];
   logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
   logic [31:0]         data_q  [SETS][WAYS][LINE_WORDS];

   logic [31:0]          addr32, idx_full, tag_full, word_full;
   logic [INDEX_W-1:0]   idx;
   logic [TAG_BITS-1:0]  tag;
   logic [WORD_BITS-1:0] word;
   logic                 unused_bits;

   assign addr32      = 32'(addr);
   assign idx_full    = addr_index(addr32, ADDR_W, INDEX_W);
   assign tag_full    = addr_tag(addr32, ADDR_W, INDEX_W, OFF_BITS);
   assign word_full   = addr_word(addr32, OFF_BITS);
   assign idx         = idx_full[INDEX_W-1:0];
   assign tag         = tag_full[TAG_BITS-1:0];
   assign word        = word_full[WORD_BITS-1:0];
   assign unused_bits = ^{idx_full[31:INDEX_W], tag_full[31:TAG_BITS], word_full[31:WORD_BITS]};

   logic                hit;
   logic [WAY_BITS-1:0] hit_way, victim, access_way;
   logic [WAYS-2:0]     next_tree;
   logic [31:0]         hit_word, fill_word;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
            hit     = 1'b1;
            hit_way = WAY_BITS'(w);
         end
      end
   end

   assign hit_word   = data_q[idx][hit_way][word];
   assign fill_word  = mem_rdata[32*word +: 32];
   assign access_way = (state == FILL) ? victim : hit_way;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .tree       (plru_q[idx]),
      .valid      (valid_q[idx]),
      .access_way (access_way),
      .victim     (victim),
      .next_tree  (next_tree)
   );

   // Control state, valid bits and PLRU; a pending flush clears after the fill write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         flush_pend <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  for (int s = 0; s < SETS; s++) begin
                     valid_q[s] <= '0;
                     plru_q[s]  <= '0;
                  end
               end else if (wr_en) begin
                  state <= WRITE;
               end else if (rd_en) begin
                  if (hit) plru_q[idx] <= next_tree;
                  else     state       <= FILL;
               end
            end
            FILL, WRITE: begin
               if (flush) flush_pend <= 1'b1;
               if (mem_ready) begin
                  if (state == FILL) begin
                     valid_q[idx][victim] <= 1'b1;
                     plru_q[idx]          <= next_tree;
                  end else if (hit) begin
                     plru_q[idx] <= next_tree;
                  end
                  if (flush || flush_pend) begin
                     for (int s = 0; s < SETS; s++) begin
                        valid_q[s] <= '0;
                        plru_q[s]  <= '0;
                     end
                  end
                  flush_pend <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && mem_ready) begin
         if (state == FILL) begin
            tag_q[idx][victim] <= tag;
            for (int k = 0; k < LINE_WORDS; k++) data_q[idx][victim][k] <= mem_rdata[32*k +: 32];
         end else if ((state == WRITE) && hit) begin
            data_q[idx][hit_way][word] <= wdata;
         end
      end
   end

   assign mem_rd_en = (state == FILL);
   assign mem_wr_en = (state == WRITE);

   always_comb begin
      ready     = 1'b0;
      rdata     = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (!flush && !wr_en) begin
               if (!rd_en) begin
                  ready = 1'b1;
               end else if (hit) begin
                  ready = 1'b1;
                  rdata = hit_word;
               end
            end
         end
         FILL: begin
            mem_addr = {addr[ADDR_W-1:OFF_BITS+2], {(OFF_BITS+2){1'b0}}};
            if (mem_ready) begin
               ready = 1'b1;
               rdata = fill_word;
            end
         end
         WRITE: begin
            mem_addr  = addr;
            mem_wdata = wdata;
            ready     = mem_ready;
         end
         default: ready = 1'b0;
      endcase
   end
endmodule
